uart_word_sender: RTL and testbench

- Upstream feeder for the byte-wide UART transmitter.
- Accepts 32-bit words from the debug/result path over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word into four bytes, LSB first, and drives the transmitter's din/tx_start pair.
- Paces itself on the transmitter's tx_done_tick level, which is high whenever the transmitter sits idle.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_word_sender.sv | 116 +++++++++++
 tb/tb_uart_word_sender.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART rx/tx blocks and the word sender:
// frame bit levels, default widths and the sender's one-hot state encoding.
package uart_pkg;

  localparam int N_DATA = 8;
  localparam int N_WORD = 32;

  localparam logic START_VALUE = 1'b0;
  localparam logic STOP_VALUE  = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_SEND = 4'b0010,
    S_ACK  = 4'b0100,
    S_WAIT = 4'b1000
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO. The head entry is read straight from the storage
// registers, so a written word is visible on dout the cycle after the write.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             push_en, pop_en;

  // A push while full is dropped even when a pop frees a slot in the same cycle.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_word_sender.sv
// Buffers 32-bit words and feeds them LSB byte first to a byte-wide UART
// transmitter, pacing each byte on the transmitter's idle level.
module uart_word_sender
  import uart_pkg::*;
#(
  parameter int N_WORD     = uart_pkg::N_WORD,
  parameter int N_DATA     = uart_pkg::N_DATA,
  parameter int N_BYTES    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2,
  parameter int NB_STATE   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_WORD-1:0]   word_in,
  input  logic                word_valid,
  output logic                word_ready,
  input  logic                tx_done_tick,
  output logic [N_DATA-1:0]   tx_din,
  output logic                tx_start,
  output logic                busy,
  output logic [ADDR_W:0]     fifo_count,
  output logic [NB_STATE-1:0] state
);

  localparam int BW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  state_t            state_q, state_d;
  logic [BW-1:0]     byte_idx_q, byte_idx_d;
  logic [N_WORD-1:0] word_q, word_d;
  logic [N_DATA-1:0] din_q, din_d;
  logic              start_q, start_d;

  logic              fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [N_WORD-1:0] fifo_dout;

  sync_fifo #(
    .WIDTH (N_WORD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (word_valid),
    .pop   (fifo_pop),
    .din   (word_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    din_d      = din_q;
    start_d    = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_dout;
          byte_idx_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_done_tick) begin
          din_d   = word_q[byte_idx_q*N_DATA +: N_DATA];
          start_d = 1'b1;
          state_d = S_ACK;
        end
      end
      // The transmitter dropping its idle level confirms it took the byte.
      S_ACK: begin
        if (!tx_done_tick) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick) begin
          if (byte_idx_q == BW'(N_BYTES - 1)) begin
            state_d = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      word_q     <= '0;
      din_q      <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      din_q      <= din_d;
      start_q    <= start_d;
    end
  end

  assign tx_din     = din_q;
  assign tx_start   = start_q;
  assign word_ready = ~fifo_full;
  assign busy       = (state_q != S_IDLE) | ~fifo_empty;
  assign state      = state_q;

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender: a timed transmitter model plus a word-to-byte
// scoreboard, checked every cycle, with directed and randomised phases.
module tb_uart_word_sender;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        tx_done_tick;
  logic [7:0]  tx_din;
  logic        tx_start;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [3:0]  state;

  logic        hold_busy = 1'b0;
  int          frame_len = 8;
  int          busy_cnt = 0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  sent_q[$];
  logic [31:0] wq[$];

  uart_word_sender dut (
    .clock        (clock),
    .reset        (reset),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .tx_done_tick (tx_done_tick),
    .tx_din       (tx_din),
    .tx_start     (tx_start),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .state        (state)
  );

  always #5 clock = ~clock;

  // Transmitter: idle unless held, busy for frame_len clocks after a start.
  assign tx_done_tick = !hold_busy && (busy_cnt == 0);

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset)            busy_cnt <= 0;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      else if (tx_start)     busy_cnt <= frame_len;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the byte scoreboard and the output rules.
  initial begin
    logic       prev_start;
    logic [7:0] last_din;
    prev_start = 1'b0;
    last_din   = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_q.delete();
        prev_start = 1'b0;
        last_din   = 8'h00;
      end else begin
        if (word_valid && word_ready)
          for (int b = 0; b < 4; b++) exp_q.push_back(word_in[b*8 +: 8]);
        if (tx_start) begin
          check("start_width", prev_start, 1'b0);
          if (exp_q.size() == 0) begin
            check("unexpected_start", 1'b1, 1'b0);
          end else begin
            check("tx_din_order", tx_din, exp_q.pop_front());
          end
          sent_q.push_back(tx_din);
        end else begin
          check("tx_din_hold", tx_din, last_din);
        end
        check("state_onehot", $onehot(state), 1'b1);
        check("ready_vs_full", word_ready, fifo_count != 3'd4);
        check("count_range", fifo_count <= 3'd4, 1'b1);
        check("busy_rule", busy, (state != 4'b0001) || (fifo_count != 3'd0));
        prev_start = tx_start;
        last_din   = tx_din;
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input int limit);
    bit ok = 1'b0;
    @(posedge clock); #1;
    word_in    = w;
    word_valid = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (word_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    word_valid = 1'b0;
    check("push_accept", ok, 1'b1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (!busy && tx_done_tick && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    bit          reached;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_din", tx_din, 8'h00);
    check("rst_state", state, 4'b0001);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ready", word_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    #19 reset = 1'b1;

    // Single word with latency pinned cycle by cycle
    sent_q.delete();
    @(posedge clock); #1;
    word_in = 32'hA1B2C3D4;
    word_valid = 1'b1;
    @(posedge clock); #1;           // E0: accepted
    word_valid = 1'b0;
    @(negedge clock);
    check("lat_e0_count", fifo_count, 3'd1);
    check("lat_e0_state", state, 4'b0001);
    @(negedge clock);               // after E1: popped
    check("lat_e1_state", state, 4'b0010);
    check("lat_e1_start", tx_start, 1'b0);
    check("lat_e1_count", fifo_count, 3'd0);
    @(negedge clock);               // after E2: first request
    check("lat_e2_start", tx_start, 1'b1);
    check("lat_e2_din", tx_din, 8'hD4);
    wait_idle("single_idle", 500);
    check("single_nbytes", sent_q.size(), 4);
    if (sent_q.size() == 4) begin
      check("single_b0", sent_q[0], 8'hD4);
      check("single_b1", sent_q[1], 8'hC3);
      check("single_b2", sent_q[2], 8'hB2);
      check("single_b3", sent_q[3], 8'hA1);
    end
    check("single_busy", busy, 1'b0);
    check("single_count", fifo_count, 3'd0);

    // Back-pressure, then a stalled S_SEND with an ignored sixth push
    sent_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_word(32'h10000001 + i, 100);
    @(negedge clock);
    check("bp_count", fifo_count, 3'd4);
    check("bp_ready", word_ready, 1'b0);
    check("bp_state", state, 4'b0010);
    @(posedge clock); #1;
    word_in = 32'h10000006;
    word_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      check("stall_state", state, 4'b0010);
      check("stall_start", tx_start, 1'b0);
      check("stall_din", tx_din, 8'hA1);
      check("stall_count", fifo_count, 3'd4);
    end
    @(posedge clock); #1;
    word_valid = 1'b0;
    hold_busy = 1'b0;
    wait_idle("bp_idle", 3000);
    check("bp_nbytes", sent_q.size(), 20);
    if (sent_q.size() == 20)
      for (int i = 0; i < 5; i++) begin
        w = 32'h10000001 + i;
        for (int b = 0; b < 4; b++) check("bp_byte", sent_q[4*i+b], w[b*8 +: 8]);
      end

    // Push held against a full FIFO while it drains
    sent_q.delete();
    hold_busy = 1'b1;
    for (int i = 1; i <= 5; i++) push_word(i, 100);
    @(negedge clock);
    check("full_count", fifo_count, 3'd4);
    fork
      push_word(32'h00000006, 3000);
      begin
        repeat (5) @(posedge clock);
        #1 hold_busy = 1'b0;
      end
    join
    wait_idle("full_idle", 3000);
    check("full_nbytes", sent_q.size(), 24);
    if (sent_q.size() == 24)
      for (int i = 0; i < 6; i++)
        for (int b = 0; b < 4; b++)
          check("full_byte", sent_q[4*i+b], (b == 0) ? (i + 1) : 0);

    // Asynchronous reset in the middle of a word
    sent_q.delete();
    frame_len = 12;
    push_word(32'h55667788, 100);
    push_word(32'h99AABBCC, 100);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (sent_q.size() == 2) begin
        reached = 1'b1;
        break;
      end
    end
    check("mid_reached", reached, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("mid_start", tx_start, 1'b0);
    check("mid_state", state, 4'b0001);
    check("mid_count", fifo_count, 3'd0);
    check("mid_ready", word_ready, 1'b1);
    check("mid_busy", busy, 1'b0);
    #8 reset = 1'b1;
    sent_q.delete();
    push_word(32'h11223344, 100);
    wait_idle("after_rst_idle", 500);
    check("after_rst_nbytes", sent_q.size(), 4);
    if (sent_q.size() == 4) begin
      check("after_rst_b0", sent_q[0], 8'h44);
      check("after_rst_b1", sent_q[1], 8'h33);
      check("after_rst_b2", sent_q[2], 8'h22);
      check("after_rst_b3", sent_q[3], 8'h11);
    end

    // Randomised stream through wrapping pointers
    sent_q.delete();
    wq.delete();
    for (int i = 0; i < 40; i++) begin
      w = (i < 10) ? (32'hCAFE0000 + i) : $urandom;
      wq.push_back(w);
      frame_len = $urandom_range(1, 15);
      push_word(w, 4000);
      repeat ($urandom_range(0, 6)) @(posedge clock);
    end
    wait_idle("stream_idle", 20000);
    check("stream_nbytes", sent_q.size(), 160);
    if (sent_q.size() == 160)
      for (int i = 0; i < 40; i++)
        for (int b = 0; b < 4; b++)
          check("stream_byte", sent_q[4*i+b], (wq[i] >> (8*b)) & 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
